// File: rtl/pmod_da2_tx.sv
// pmod_da2_tx: serial transmitter for a Pmod DA2 (DAC121S101-class, 12-bit).
// Accepts a DAC code over a valid/ready handshake. Each accepted word is sent
// as one 16-bit frame {2'b00, mode, din}, MSB first, on a sync_n/sclk/sdata link.
// Optional build macro DUAL_CH_EN adds a second data lane (din_b -> sdata_b).
// That lane shares sync_n and sclk with channel A and shifts in lockstep with it.
module pmod_da2_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        mode,
  input  logic              din_valid,
`ifdef DUAL_CH_EN
  input  logic [DATA_W-1:0] din_b,
  output logic              sdata_b,
`endif
  output logic              din_ready,
  output logic              busy,
  output logic              sync_n,
  output logic              sclk,
  output logic              sdata_a
);

  localparam int unsigned FRAME_W = DATA_W + 4;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned HP_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  // Stop elaboration on parameter values this part cannot support.
  if (DATA_W != 12) begin : g_bad_data_w
    $error("pmod_da2_tx: DATA_W must be 12");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("pmod_da2_tx: CLK_DIV must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_GAP
  } state_t;

  state_t               state_q,  state_nxt;
  logic [HP_W-1:0]      hp_q,     hp_nxt;
  logic [BIT_W-1:0]     bit_q,    bit_nxt;
  logic [FRAME_W-1:0]   sh_a_q,   sh_a_nxt;
`ifdef DUAL_CH_EN
  logic [FRAME_W-1:0]   sh_b_q,   sh_b_nxt;
`endif

  logic sync_n_nxt;
  logic sclk_nxt;
  logic ready_nxt;
  logic busy_nxt;

  logic accept;
  logic hp_tc;

  assign accept = din_valid && din_ready;
  assign hp_tc  = (hp_q == HP_LAST);

  // The serial data pins come straight from the shift-register MSBs.
  // A register clears to zero after its last shift, so sdata reads 0 in GAP and IDLE.
  assign sdata_a = sh_a_q[FRAME_W-1];
`ifdef DUAL_CH_EN
  assign sdata_b = sh_b_q[FRAME_W-1];
`endif

  // State, counters, shift registers and registered pin outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hp_q      <= '0;
      bit_q     <= '0;
      sh_a_q    <= '0;
`ifdef DUAL_CH_EN
      sh_b_q    <= '0;
`endif
      sync_n    <= 1'b1;
      sclk      <= 1'b1;
      din_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      hp_q      <= hp_nxt;
      bit_q     <= bit_nxt;
      sh_a_q    <= sh_a_nxt;
`ifdef DUAL_CH_EN
      sh_b_q    <= sh_b_nxt;
`endif
      sync_n    <= sync_n_nxt;
      sclk      <= sclk_nxt;
      din_ready <= ready_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state logic. Every non-idle state lasts one half-period of CLK_DIV clocks.
  // The shift registers advance when a LOW ends, so new data appears when HIGH starts.
  always_comb begin
    state_nxt = state_q;
    hp_nxt    = hp_q;
    bit_nxt   = bit_q;
    sh_a_nxt  = sh_a_q;
`ifdef DUAL_CH_EN
    sh_b_nxt  = sh_b_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_SETUP;
          hp_nxt    = '0;
          bit_nxt   = BIT_LAST;
          sh_a_nxt  = {2'b00, mode, din};
`ifdef DUAL_CH_EN
          sh_b_nxt  = {2'b00, mode, din_b};
`endif
        end
      end
      S_SETUP: begin
        if (hp_tc) begin
          state_nxt = S_LOW;
          hp_nxt    = '0;
        end else begin
          hp_nxt    = hp_q + HP_W'(1);
        end
      end
      S_LOW: begin
        if (hp_tc) begin
          hp_nxt   = '0;
          sh_a_nxt = {sh_a_q[FRAME_W-2:0], 1'b0};
`ifdef DUAL_CH_EN
          sh_b_nxt = {sh_b_q[FRAME_W-2:0], 1'b0};
`endif
          if (bit_q == '0) begin
            state_nxt = S_GAP;
          end else begin
            state_nxt = S_HIGH;
            bit_nxt   = bit_q - BIT_W'(1);
          end
        end else begin
          hp_nxt = hp_q + HP_W'(1);
        end
      end
      S_HIGH: begin
        if (hp_tc) begin
          state_nxt = S_LOW;
          hp_nxt    = '0;
        end else begin
          hp_nxt    = hp_q + HP_W'(1);
        end
      end
      S_GAP: begin
        if (hp_tc) begin
          state_nxt = S_IDLE;
          hp_nxt    = '0;
        end else begin
          hp_nxt    = hp_q + HP_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        hp_nxt    = '0;
      end
    endcase
  end

  // Pin values for the upcoming state. These are registered, so the pins follow the state with no skew.
  always_comb begin
    sync_n_nxt = 1'b1;
    sclk_nxt   = 1'b1;
    ready_nxt  = 1'b0;
    busy_nxt   = 1'b0;
    case (state_nxt)
      S_IDLE: begin
        ready_nxt = 1'b1;
      end
      S_SETUP, S_HIGH: begin
        sync_n_nxt = 1'b0;
        busy_nxt   = 1'b1;
      end
      S_LOW: begin
        sync_n_nxt = 1'b0;
        sclk_nxt   = 1'b0;
        busy_nxt   = 1'b1;
      end
      S_GAP: begin
        busy_nxt = 1'b1;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pmod_da2_tx.sv
// Directed bench for pmod_da2_tx: table of single frames plus hand-written
// back-to-back, mid-frame reset and CLK_DIV=1 sequences. Captures frames the way
// the DAC would, shifting sdata in on every sclk falling edge while sync_n is low.
module tb_pmod_da2_tx;

  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [11:0] din = '0;
  logic [1:0]  mode = '0;
  logic        din_valid = 1'b0;
  logic        din_ready, busy, sync_n, sclk, sdata_a;

  logic [11:0] d1_din = '0;
  logic [1:0]  d1_mode = '0;
  logic        d1_valid = 1'b0;
  logic        d1_ready, d1_busy, d1_sync_n, d1_sclk, d1_sdata_a;

`ifdef DUAL_CH_EN
  logic [11:0] din_b = 12'h3C3;
  logic        sdata_b;
  logic [11:0] d1_din_b = '0;
  logic        d1_sdata_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pmod_da2_tx #(.CLK_DIV(4), .DATA_W(12)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .mode      (mode),
    .din_valid (din_valid),
`ifdef DUAL_CH_EN
    .din_b     (din_b),
    .sdata_b   (sdata_b),
`endif
    .din_ready (din_ready),
    .busy      (busy),
    .sync_n    (sync_n),
    .sclk      (sclk),
    .sdata_a   (sdata_a)
  );

  pmod_da2_tx #(.CLK_DIV(1), .DATA_W(12)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (d1_din),
    .mode      (d1_mode),
    .din_valid (d1_valid),
`ifdef DUAL_CH_EN
    .din_b     (d1_din_b),
    .sdata_b   (d1_sdata_b),
`endif
    .din_ready (d1_ready),
    .busy      (d1_busy),
    .sync_n    (d1_sync_n),
    .sclk      (d1_sclk),
    .sdata_a   (d1_sdata_a)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reset as seen by the DUTs at the last clock edge.
  logic rst_s = 1'b0;
  always @(posedge clk) rst_s <= rst_n;

  // DAC-side model for the CLK_DIV=4 instance.
  logic        p_sclk4 = 1'b1, p_sync4 = 1'b1, p_sd4 = 1'b0;
  int          fe4 = 0, lo4 = 0, hi4 = 0, stab4 = 0, stab_err4 = 0, last_gap4 = 0;
  int          inv_err = 0;
  logic [15:0] w4 = '0;
  logic [15:0] q_word4[$];
  int          q_fe4[$];
  int          q_lo4[$];

  always @(negedge clk) begin
    stab4 = (sdata_a === p_sd4) ? stab4 + 1 : 0;
    if (!sync_n && p_sclk4 && !sclk) begin
      w4 = {w4[14:0], sdata_a};
      fe4++;
      if (stab4 < 4) stab_err4++;
    end
    if (sync_n && !p_sync4) begin
      q_word4.push_back(w4);
      q_fe4.push_back(fe4);
      q_lo4.push_back(lo4);
      w4 = '0; fe4 = 0; lo4 = 0;
    end
    if (!sync_n && p_sync4) begin
      last_gap4 = hi4;
      hi4 = 0;
    end
    if (!sync_n) lo4++;
    else         hi4++;
    if (rst_s && (busy !== ~din_ready)) inv_err++;
`ifdef DUAL_CH_EN
    if (sync_n && sdata_b !== 1'b0) inv_err++;
`endif
    p_sclk4 = sclk; p_sync4 = sync_n; p_sd4 = sdata_a;
  end

  // DAC-side model for the CLK_DIV=1 instance.
  logic        p_sclk1 = 1'b1, p_sync1 = 1'b1, p_sd1 = 1'b0;
  int          fe1 = 0, lo1 = 0, stab1 = 0, stab_err1 = 0;
  logic [15:0] w1a = '0;
  logic [15:0] q_word1[$];
  int          q_fe1[$];
  int          q_lo1[$];
`ifdef DUAL_CH_EN
  logic [15:0] w1b = '0;
  logic [15:0] q_wordb1[$];
`endif

  always @(negedge clk) begin
    stab1 = (d1_sdata_a === p_sd1) ? stab1 + 1 : 0;
    if (!d1_sync_n && p_sclk1 && !d1_sclk) begin
      w1a = {w1a[14:0], d1_sdata_a};
`ifdef DUAL_CH_EN
      w1b = {w1b[14:0], d1_sdata_b};
`endif
      fe1++;
      if (stab1 < 1) stab_err1++;
    end
    if (d1_sync_n && !p_sync1) begin
      q_word1.push_back(w1a);
      q_fe1.push_back(fe1);
      q_lo1.push_back(lo1);
`ifdef DUAL_CH_EN
      q_wordb1.push_back(w1b);
      w1b = '0;
`endif
      w1a = '0; fe1 = 0; lo1 = 0;
    end
    if (!d1_sync_n) lo1++;
    if (rst_s && (d1_busy !== ~d1_ready)) inv_err++;
    p_sclk1 = d1_sclk; p_sync1 = d1_sync_n; p_sd1 = d1_sdata_a;
  end

  task automatic wait_ready4(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (din_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ready1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (d1_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Counts the samples with din_ready low, starting just after the accept edge.
  task automatic busy_len4(output int nb);
    nb = 0;
    while (!din_ready && nb < TMO) begin
      nb++;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [11:0] din;
    logic [1:0]  mode;
    logic [15:0] exp_word;
  } vec_t;

  vec_t        tv[4];
  bit          ok;
  int          nb;
  logic [15:0] wd;
  int          fe, lo;

  initial begin
    tv[0] = '{din: 12'hABC, mode: 2'b00, exp_word: 16'h0ABC};
    tv[1] = '{din: 12'h000, mode: 2'b11, exp_word: 16'h3000};
    tv[2] = '{din: 12'h800, mode: 2'b01, exp_word: 16'h1800};
    tv[3] = '{din: 12'h5A5, mode: 2'b10, exp_word: 16'h25A5};

    // Reset held with din_valid high: pins at reset values, nothing accepted.
    rst_n = 1'b0; din = 12'hABC; din_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("rst_sync_n", 32'(sync_n), 1);
      chk("rst_sclk", 32'(sclk), 1);
      chk("rst_sdata_a", 32'(sdata_a), 0);
      chk("rst_din_ready", 32'(din_ready), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    din_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(din_ready), 1);
    chk("no_frame_in_rst", 32'(q_word4.size()), 0);

    // Table of single frames with one-cycle valid.
    foreach (tv[i]) begin
      wait_ready4(ok);
      chk($sformatf("v%0d_ready", i), 32'(ok), 1);
      din = tv[i].din; mode = tv[i].mode; din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0; din = ~tv[i].din; mode = ~tv[i].mode;
      busy_len4(nb);
      chk($sformatf("v%0d_busy_cycles", i), 32'(nb), 132);
      chk($sformatf("v%0d_nframes", i), 32'(q_word4.size()), 1);
      if (q_word4.size() > 0) begin
        wd = q_word4.pop_front(); fe = q_fe4.pop_front(); lo = q_lo4.pop_front();
        chk($sformatf("v%0d_word", i), 32'(wd), 32'(tv[i].exp_word));
        chk($sformatf("v%0d_falls", i), 32'(fe), 16);
        chk($sformatf("v%0d_sync_low", i), 32'(lo), 128);
      end
    end

    // Back-to-back with din_valid held; din changed while the first frame is in flight.
    din = 12'h001; mode = 2'b00; din_valid = 1'b1;
    wait_ready4(ok);
    @(posedge clk); #1;
    din = 12'hFFF;
    wait_ready4(ok);
    chk("b2b_second_ready", 32'(ok), 1);
    @(posedge clk); #1;
    din_valid = 1'b0; din = 12'h000;
    busy_len4(nb);
    chk("b2b_second_busy", 32'(nb), 132);
    chk("b2b_nframes", 32'(q_word4.size()), 2);
    chk("b2b_gap_ge5", 32'(last_gap4 >= 5), 1);
    if (q_word4.size() >= 2) begin
      wd = q_word4.pop_front(); fe = q_fe4.pop_front(); lo = q_lo4.pop_front();
      chk("b2b_word0", 32'(wd), 32'h0001);
      chk("b2b_falls0", 32'(fe), 16);
      wd = q_word4.pop_front(); fe = q_fe4.pop_front(); lo = q_lo4.pop_front();
      chk("b2b_word1", 32'(wd), 32'h0FFF);
      chk("b2b_falls1", 32'(fe), 16);
    end
    q_word4.delete(); q_fe4.delete(); q_lo4.delete();

    // Reset after the 7th falling edge aborts the frame; the next frame carries the new word.
    din = 12'h777; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    nb = 0;
    while (fe4 < 7 && nb < TMO) begin
      nb++;
      @(posedge clk); #1;
    end
    chk("mid_seven_falls", 32'(fe4 >= 7), 1);
    rst_n = 1'b0; din = 12'h555; din_valid = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_sync_n", 32'(sync_n), 1);
    chk("mid_rst_sclk", 32'(sclk), 1);
    chk("mid_rst_ready", 32'(din_ready), 0);
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    wait_ready4(ok);
    @(posedge clk); #1;
    din_valid = 1'b0;
    busy_len4(nb);
    chk("mid_nframes", 32'(q_word4.size()), 2);
    if (q_word4.size() >= 2) begin
      wd = q_word4.pop_front(); fe = q_fe4.pop_front(); lo = q_lo4.pop_front();
      chk("mid_partial_lt16", 32'(fe < 16), 1);
      wd = q_word4.pop_front(); fe = q_fe4.pop_front(); lo = q_lo4.pop_front();
      chk("mid_new_word", 32'(wd), 32'h0555);
      chk("mid_new_falls", 32'(fe), 16);
    end

    // CLK_DIV=1 instance: sclk = clk/2; the second lane (when built) shares the same falling edges.
    d1_din = 12'h123; d1_mode = 2'b00; d1_valid = 1'b1;
`ifdef DUAL_CH_EN
    d1_din_b = 12'hFED;
`endif
    wait_ready1(ok);
    @(posedge clk); #1;
    d1_valid = 1'b0; d1_din = 12'h000;
    nb = 0;
    while (!d1_ready && nb < TMO) begin
      nb++;
      @(posedge clk); #1;
    end
    chk("d1_busy_cycles", 32'(nb), 33);
    chk("d1_nframes", 32'(q_word1.size()), 1);
    if (q_word1.size() > 0) begin
      chk("d1_word_a", 32'(q_word1[0]), 32'h0123);
      chk("d1_falls", 32'(q_fe1[0]), 16);
      chk("d1_sync_low", 32'(q_lo1[0]), 32);
`ifdef DUAL_CH_EN
      chk("d1_word_b", 32'(q_wordb1[0]), 32'h0FED);
`endif
    end

    chk("sdata_setup_4", 32'(stab_err4), 0);
    chk("sdata_setup_1", 32'(stab_err1), 0);
    chk("busy_vs_ready", 32'(inv_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
